// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared sizes, state encoding, entry layout and PC slicing
//               helpers for the branch target buffer (also used by the BHT).
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    localparam int ENTRIES = 256;
    localparam int IDX_W   = 8;
    localparam int TAG_W   = 32 - IDX_W - 2;
    localparam int TGT_W   = 30;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } btb_state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
    } btb_entry_t;

    // Direct-mapped index: word address bits just above the byte offset.
    function automatic logic [IDX_W-1:0] btb_index(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    // Tag: everything above the index.
    function automatic logic [TAG_W-1:0] btb_tag(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_init_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : btb_init_sweeper
// Description : INIT/RUN controller. After reset it walks every entry index
//               once, requesting a valid-bit clear, then enters RUN for good.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_init_sweeper
    import btb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_i,
    output logic             init_busy,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ENTRIES - 1);

    btb_state_t       r_state;
    btb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;

    // State register and sweep counter; reset restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state   <= INIT;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_clr_idx <= r_clr_idx + IDX_W'(1);
            end
        end
    end

    // Next state and outputs: leave INIT once the last index has been cleared.
    always_comb begin
        w_state_nxt = r_state;
        init_busy   = 1'b0;
        clr_en      = 1'b0;
        case (r_state)
            INIT: begin
                init_busy = 1'b1;
                clr_en    = 1'b1;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign clr_idx = r_clr_idx;

endmodule
`default_nettype wire

// File: rtl/btb_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : btb_target_buffer
// Description : Direct-mapped branch target buffer with write-first bypass,
//               misprediction redirect and next-PC selection for IF.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_target_buffer
    import btb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic [31:0] if_pc,
    input  logic        bht_taken,
    input  logic        mem_is_branch,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_target,
    input  logic        PCSrc,
    input  logic        miss_predict,
    output logic        btb_hit,
    output logic [31:0] btb_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        init_busy
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    btb_entry_t       r_entry [ENTRIES];

    logic             w_clr_en;
    logic [IDX_W-1:0] w_clr_idx;
    logic             w_run;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_mem_idx;
    logic [TAG_W-1:0] w_mem_tag;

    logic             w_upd;
    logic             w_bypass;
    btb_entry_t       w_if_rd;
    btb_entry_t       w_if_eff;
    btb_entry_t       w_mem_rd;
    logic             w_mem_hit;
    logic [31:0]      w_mem_pred;
    logic [31:0]      w_if_pc_plus4;
    logic [31:0]      w_mem_pc_plus4;

    btb_init_sweeper u_sweeper (
        .clk       (clk),
        .rst_i     (rst_i),
        .init_busy (init_busy),
        .clr_en    (w_clr_en),
        .clr_idx   (w_clr_idx)
    );

    assign w_run          = ~init_busy;
    assign w_if_idx       = btb_index(if_pc);
    assign w_if_tag       = btb_tag(if_pc);
    assign w_mem_idx      = btb_index(mem_pc);
    assign w_mem_tag      = btb_tag(mem_pc);
    assign w_if_pc_plus4  = if_pc + c_PC_STEP;
    assign w_mem_pc_plus4 = mem_pc + c_PC_STEP;

    // Only resolved-taken branches allocate; not-taken leaves the entry alone.
    assign w_upd = w_run & mem_is_branch & PCSrc;

    // Storage: the sweep clears valid bits; in RUN a taken branch overwrites its slot.
    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_entry[w_clr_idx].valid <= 1'b0;
        end else if (w_upd) begin
            r_entry[w_mem_idx].valid  <= 1'b1;
            r_entry[w_mem_idx].tag    <= w_mem_tag;
            r_entry[w_mem_idx].target <= mem_target[31:2];
        end
    end

    // IF lookup with write-first bypass of a same-index update.
    always_comb begin
        w_if_rd  = r_entry[w_if_idx];
        w_bypass = w_upd && (w_mem_idx == w_if_idx);
        w_if_eff = w_if_rd;
        if (w_bypass) begin
            w_if_eff.valid  = 1'b1;
            w_if_eff.tag    = w_mem_tag;
            w_if_eff.target = mem_target[31:2];
        end
        btb_hit    = w_run && w_if_eff.valid && (w_if_eff.tag == w_if_tag);
        btb_target = btb_hit ? {w_if_eff.target, 2'b00} : 32'd0;
    end

    // Target predicted for the MEM-stage branch, rebuilt from the current
    // contents at mem_pc: a hit supplied the stored target, a miss fell
    // through to mem_pc+4. Uses pre-update contents (no bypass).
    always_comb begin
        w_mem_rd   = r_entry[w_mem_idx];
        w_mem_hit  = w_mem_rd.valid && (w_mem_rd.tag == w_mem_tag);
        w_mem_pred = w_mem_hit ? {w_mem_rd.target, 2'b00} : w_mem_pc_plus4;
        redirect   = w_run && mem_is_branch &&
                     (miss_predict || (PCSrc && (mem_target != w_mem_pred)));
    end

    // Next-PC mux: redirect beats prediction, prediction beats sequential.
    always_comb begin
        next_pc = w_if_pc_plus4;
        if (redirect) begin
            next_pc = PCSrc ? mem_target : w_mem_pc_plus4;
        end else if (bht_taken && btb_hit) begin
            next_pc = btb_target;
        end
    end

endmodule
`default_nettype wire
